// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: SPI-mode-0 receiver for an LCD controller command stream.
// Recovers bytes from an asynchronous SPI link and decodes the CASET, RASET
// and RAMWR commands. RAMWR data becomes RGB565 pixels with window-relative
// coordinates.
module lcd_spi_rx #(
    parameter int ADDR_W = 9
) (
    input  logic              sys_clk_50MHz,
    input  logic              sys_rst_n,
    input  logic              lcd_cs,
    input  logic              lcd_sclk,
    input  logic              lcd_mosi,
    input  logic              lcd_dc,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              byte_dc,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_x,
    output logic [ADDR_W-1:0] pix_y,
    output logic [15:0]       pix_data,
    output logic              cmd_valid
);

    localparam logic [7:0] CODE_CASET = 8'h2A;
    localparam logic [7:0] CODE_RASET = 8'h2B;
    localparam logic [7:0] CODE_RAMWR = 8'h2C;

    typedef enum logic [1:0] {
        IDLE,
        CASET,
        RASET,
        RAMWR
    } state_t;

    // Synchronised versions of the SPI pins and the sclk edge detector
    logic [1:0] cs_sync;
    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [1:0] dc_sync;
    logic       sclk_prev;
    logic       cs_s;
    logic       mosi_s;
    logic       dc_s;
    logic       sclk_rise;

    // Byte assembly
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [7:0] rx_byte;
    logic       rx_dc;
    logic       rx_done;

    // Command decoder state and window / cursor registers
    state_t            state_q;
    state_t            state_d;
    logic [1:0]        param_cnt;
    logic [7:0]        par_sh;
    logic [7:0]        par_sl;
    logic [7:0]        par_eh;
    logic [ADDR_W-1:0] xs;
    logic [ADDR_W-1:0] xe;
    logic [ADDR_W-1:0] ys;
    logic [ADDR_W-1:0] ye;
    logic [ADDR_W-1:0] cur_x;
    logic [ADDR_W-1:0] cur_y;
    logic [ADDR_W-1:0] next_x;
    logic [ADDR_W-1:0] next_y;
    logic              half;
    logic [7:0]        hi_byte;

    // Per-byte decode strobes
    logic is_cmd;
    logic is_param;
    logic is_pixel_byte;
    logic x_wrap;
    logic y_wrap;

    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign dc_s      = dc_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_prev;

    // Two-flop synchronisers for every SPI pin. The previous synchronised
    // sclk value is kept for rising-edge detection.
    always_ff @(posedge sys_clk_50MHz) begin
        if (!sys_rst_n) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            dc_sync   <= 2'b00;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], lcd_cs};
            sclk_sync <= {sclk_sync[0], lcd_sclk};
            mosi_sync <= {mosi_sync[0], lcd_mosi};
            dc_sync   <= {dc_sync[0], lcd_dc};
            sclk_prev <= sclk_sync[1];
        end
    end

    // Shift in mosi MSB first. The 8th bit completes a byte and captures dc.
    // While cs is high, any partial byte is dropped.
    always_ff @(posedge sys_clk_50MHz) begin
        if (!sys_rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            rx_byte   <= '0;
            rx_dc     <= 1'b0;
            rx_done   <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (cs_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_reg <= {shift_reg[5:0], mosi_s};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte <= {shift_reg, mosi_s};
                    rx_dc   <= dc_s;
                    rx_done <= 1'b1;
                end
            end
        end
    end

    // Classify each completed byte. Compute the cursor position that
    // follows the current pixel. An inverted window range pins that axis
    // to its start.
    always_comb begin
        is_cmd        = rx_done & ~rx_dc;
        is_param      = rx_done & rx_dc & ((state_q == CASET) | (state_q == RASET));
        is_pixel_byte = rx_done & rx_dc & (state_q == RAMWR);
        x_wrap        = (xs > xe) | (cur_x == xe);
        y_wrap        = (ys > ye) | (cur_y == ye);
        next_x        = cur_x + {{(ADDR_W-1){1'b0}}, 1'b1};
        next_y        = cur_y;
        if (x_wrap) begin
            next_x = xs;
            next_y = y_wrap ? ys : (cur_y + {{(ADDR_W-1){1'b0}}, 1'b1});
        end
    end

    // Decoder state register
    always_ff @(posedge sys_clk_50MHz) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a command byte always selects the new state. The 4th
    // window parameter returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (is_cmd) begin
            case (rx_byte)
                CODE_CASET: state_d = CASET;
                CODE_RASET: state_d = RASET;
                CODE_RAMWR: state_d = RAMWR;
                default:    state_d = IDLE;
            endcase
        end else if (is_param && (param_cnt == 2'd3)) begin
            state_d = IDLE;
        end
    end

    // Output strobes, window parameter capture, and pixel assembly with
    // cursor advance
    always_ff @(posedge sys_clk_50MHz) begin
        if (!sys_rst_n) begin
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
            cmd_valid  <= 1'b0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            param_cnt  <= '0;
            par_sh     <= '0;
            par_sl     <= '0;
            par_eh     <= '0;
            xs         <= '0;
            xe         <= '1;
            ys         <= '0;
            ye         <= '1;
            cur_x      <= '0;
            cur_y      <= '0;
            half       <= 1'b0;
            hi_byte    <= '0;
        end else begin
            byte_valid <= rx_done;
            cmd_valid  <= is_cmd;
            pix_valid  <= 1'b0;
            if (rx_done) begin
                byte_data <= rx_byte;
                byte_dc   <= rx_dc;
            end
            if (is_cmd) begin
                half      <= 1'b0;
                param_cnt <= '0;
                if (rx_byte == CODE_RAMWR) begin
                    cur_x <= xs;
                    cur_y <= ys;
                end
            end
            if (is_param) begin
                param_cnt <= param_cnt + 2'd1;
                case (param_cnt)
                    2'd0: par_sh <= rx_byte;
                    2'd1: par_sl <= rx_byte;
                    2'd2: par_eh <= rx_byte;
                    default: begin
                        if (state_q == CASET) begin
                            xs <= ADDR_W'({par_sh, par_sl});
                            xe <= ADDR_W'({par_eh, rx_byte});
                        end else begin
                            ys <= ADDR_W'({par_sh, par_sl});
                            ye <= ADDR_W'({par_eh, rx_byte});
                        end
                    end
                endcase
            end
            if (is_pixel_byte) begin
                if (!half) begin
                    hi_byte <= rx_byte;
                    half    <= 1'b1;
                end else begin
                    pix_valid <= 1'b1;
                    pix_x     <= cur_x;
                    pix_y     <= cur_y;
                    pix_data  <= {hi_byte, rx_byte};
                    half      <= 1'b0;
                    cur_x     <= next_x;
                    cur_y     <= next_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: scoreboard bench for lcd_spi_rx.
// A plain-arithmetic model of the LCD command protocol predicts every byte,
// command and pixel. A negedge monitor pops those predictions as the DUT
// pulses its outputs.
module tb_lcd_spi_rx;

    localparam int W    = 9;
    localparam int MASK = (1 << W) - 1;

    logic         sys_clk_50MHz = 1'b0;
    logic         sys_rst_n     = 1'b0;
    logic         lcd_cs        = 1'b1;
    logic         lcd_sclk      = 1'b0;
    logic         lcd_mosi      = 1'b0;
    logic         lcd_dc        = 1'b0;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_dc;
    logic         pix_valid;
    logic [W-1:0] pix_x;
    logic [W-1:0] pix_y;
    logic [15:0]  pix_data;
    logic         cmd_valid;

    int check_count = 0;
    int fail_count  = 0;

    // Expected-response queues, filled by the model and drained by the monitor
    logic [8:0]  exp_byte_q[$];
    logic [7:0]  exp_cmd_q[$];
    logic [33:0] exp_pix_q[$];

    // Reference model state, kept as plain integers
    int m_state;
    int m_pc;
    int m_par[4];
    int m_xs, m_xe, m_ys, m_ye;
    int m_x, m_y;
    int m_half;
    int m_hi;

    lcd_spi_rx #(.ADDR_W(W)) dut (
        .sys_clk_50MHz (sys_clk_50MHz),
        .sys_rst_n     (sys_rst_n),
        .lcd_cs        (lcd_cs),
        .lcd_sclk      (lcd_sclk),
        .lcd_mosi      (lcd_mosi),
        .lcd_dc        (lcd_dc),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_dc       (byte_dc),
        .pix_valid     (pix_valid),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_data      (pix_data),
        .cmd_valid     (cmd_valid)
    );

    // 50 MHz system clock
    always #10 sys_clk_50MHz = ~sys_clk_50MHz;

    // Compare one value and record the outcome
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Return the model to its power-on state
    task automatic modelReset();
        m_state = 0;
        m_pc    = 0;
        m_xs    = 0;
        m_ys    = 0;
        m_xe    = MASK;
        m_ye    = MASK;
        m_x     = 0;
        m_y     = 0;
        m_half  = 0;
        m_hi    = 0;
    endtask

    // Predict the DUT response to one complete byte.
    // States: 0 idle, 1 column window, 2 row window, 3 memory write.
    task automatic modelByte(input int b, input int dc);
        int s, e;
        exp_byte_q.push_back({dc[0], b[7:0]});
        if (dc == 0) begin
            exp_cmd_q.push_back(b[7:0]);
            m_half = 0;
            m_pc   = 0;
            if (b == 'h2A) m_state = 1;
            else if (b == 'h2B) m_state = 2;
            else if (b == 'h2C) begin
                m_state = 3;
                m_x     = m_xs;
                m_y     = m_ys;
            end else m_state = 0;
        end else if (m_state == 1 || m_state == 2) begin
            m_par[m_pc] = b;
            m_pc++;
            if (m_pc == 4) begin
                s = (m_par[0] * 256 + m_par[1]) & MASK;
                e = (m_par[2] * 256 + m_par[3]) & MASK;
                if (m_state == 1) begin
                    m_xs = s;
                    m_xe = e;
                end else begin
                    m_ys = s;
                    m_ye = e;
                end
                m_state = 0;
                m_pc    = 0;
            end
        end else if (m_state == 3) begin
            if (m_half == 0) begin
                m_hi   = b;
                m_half = 1;
            end else begin
                exp_pix_q.push_back({m_x[W-1:0], m_y[W-1:0], m_hi[7:0], b[7:0]});
                m_half = 0;
                if (m_xs > m_xe || m_x == m_xe) begin
                    m_x = m_xs;
                    if (m_ys > m_ye || m_y == m_ye) m_y = m_ys;
                    else m_y = (m_y + 1) & MASK;
                end else begin
                    m_x = (m_x + 1) & MASK;
                end
            end
        end
    endtask

    // Send one full byte at sclk = sys_clk/8. If check_lat is set, also
    // check that byte_valid rises exactly 4 clocks after the last sclk edge.
    task automatic applyStimulus(input logic [7:0] b, input logic dc, input bit check_lat);
        modelByte(int'(b), int'(dc));
        for (int i = 7; i >= 0; i--) begin
            @(negedge sys_clk_50MHz);
            lcd_mosi = b[i];
            lcd_dc   = dc;
            repeat (3) @(negedge sys_clk_50MHz);
            lcd_sclk = 1'b1;
            if (check_lat && i == 0) begin
                for (int k = 1; k <= 4; k++) begin
                    @(posedge sys_clk_50MHz);
                    #1;
                    checkOutput($sformatf("latency_cycle_%0d", k), 32'(byte_valid), (k == 4) ? 32'd1 : 32'd0);
                end
                repeat (4) @(negedge sys_clk_50MHz);
            end else begin
                repeat (4) @(negedge sys_clk_50MHz);
            end
            lcd_sclk = 1'b0;
        end
        repeat (3) @(negedge sys_clk_50MHz);
    endtask

    // Clock out only the top k bits of a byte. If raise_cs is set, then
    // pulse chip select high to abandon the partial byte.
    task automatic partialBits(input logic [7:0] b, input int k, input bit raise_cs);
        for (int i = 7; i > 7 - k; i--) begin
            @(negedge sys_clk_50MHz);
            lcd_mosi = b[i];
            lcd_dc   = 1'b1;
            repeat (3) @(negedge sys_clk_50MHz);
            lcd_sclk = 1'b1;
            repeat (4) @(negedge sys_clk_50MHz);
            lcd_sclk = 1'b0;
        end
        repeat (3) @(negedge sys_clk_50MHz);
        if (raise_cs) begin
            lcd_cs = 1'b1;
            repeat (5) @(negedge sys_clk_50MHz);
            lcd_cs = 1'b0;
            repeat (5) @(negedge sys_clk_50MHz);
        end
    endtask

    // Hold reset for a number of cycles and check every output is cleared
    task automatic doReset(input int cycles);
        @(negedge sys_clk_50MHz);
        sys_rst_n = 1'b0;
        repeat (cycles) @(posedge sys_clk_50MHz);
        #1;
        checkOutput("rst_byte_valid", 32'(byte_valid), 32'd0);
        checkOutput("rst_byte_data", 32'(byte_data), 32'd0);
        checkOutput("rst_byte_dc", 32'(byte_dc), 32'd0);
        checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
        checkOutput("rst_pix_x", 32'(pix_x), 32'd0);
        checkOutput("rst_pix_y", 32'(pix_y), 32'd0);
        checkOutput("rst_pix_data", 32'(pix_data), 32'd0);
        @(negedge sys_clk_50MHz);
        sys_rst_n = 1'b1;
        modelReset();
        lcd_cs = 1'b0;
        repeat (5) @(negedge sys_clk_50MHz);
    endtask

    // Send a window command with a 16-bit start and end value
    task automatic sendWindow(input logic [7:0] code, input logic [15:0] s, input logic [15:0] e);
        applyStimulus(code, 1'b0, 1'b0);
        applyStimulus(s[15:8], 1'b1, 1'b0);
        applyStimulus(s[7:0], 1'b1, 1'b0);
        applyStimulus(e[15:8], 1'b1, 1'b0);
        applyStimulus(e[7:0], 1'b1, 1'b0);
    endtask

    // Send one pixel as two data bytes
    task automatic sendPixel(input logic [15:0] p);
        applyStimulus(p[15:8], 1'b1, 1'b0);
        applyStimulus(p[7:0], 1'b1, 1'b0);
    endtask

    // Scoreboard monitor: every output pulse must match the next prediction
    always @(negedge sys_clk_50MHz) begin
        logic [8:0]  eb;
        logic [7:0]  ec;
        logic [33:0] ep;
        if (sys_rst_n) begin
            if (byte_valid) begin
                if (exp_byte_q.size() == 0) begin
                    checkOutput("unexpected_byte_valid", 32'(byte_valid), 32'd0);
                end else begin
                    eb = exp_byte_q.pop_front();
                    checkOutput("byte_data", 32'(byte_data), 32'(eb[7:0]));
                    checkOutput("byte_dc", 32'(byte_dc), 32'(eb[8]));
                end
            end
            if (cmd_valid) begin
                if (exp_cmd_q.size() == 0) begin
                    checkOutput("unexpected_cmd_valid", 32'(cmd_valid), 32'd0);
                end else begin
                    ec = exp_cmd_q.pop_front();
                    checkOutput("cmd_code", 32'(byte_data), 32'(ec));
                end
            end
            if (pix_valid) begin
                if (exp_pix_q.size() == 0) begin
                    checkOutput("unexpected_pix_valid", 32'(pix_valid), 32'd0);
                end else begin
                    ep = exp_pix_q.pop_front();
                    checkOutput("pix_x", 32'(pix_x), 32'(ep[33:25]));
                    checkOutput("pix_y", 32'(pix_y), 32'(ep[24:16]));
                    checkOutput("pix_data", 32'(pix_data), 32'(ep[15:0]));
                end
            end
        end
    end

    // Directed scenarios followed by a randomised command stream
    initial begin
        int op, n, s, e, pending;
        modelReset();
        doReset(3);

        // Single data byte with the latency check
        applyStimulus(8'hA5, 1'b1, 1'b1);

        // Partial byte abandoned by chip select, then a clean byte
        partialBits(8'hFF, 5, 1'b1);
        applyStimulus(8'h3C, 1'b1, 1'b0);

        // Window setup and five pixels wrapping around a 2x2 window
        sendWindow(8'h2A, 16'd10, 16'd11);
        sendWindow(8'h2B, 16'd20, 16'd21);
        applyStimulus(8'h2C, 1'b0, 1'b0);
        sendPixel(16'h1234);
        sendPixel(16'h5678);
        sendPixel(16'h9ABC);
        sendPixel(16'hDEF0);
        sendPixel(16'h0F0F);

        // A pending high byte is discarded by a new command
        applyStimulus(8'h2C, 1'b0, 1'b0);
        applyStimulus(8'h77, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);

        // Reset in the middle of a pixel
        applyStimulus(8'h2C, 1'b0, 1'b0);
        applyStimulus(8'hEE, 1'b1, 1'b0);
        doReset(1);
        applyStimulus(8'h2C, 1'b0, 1'b0);
        sendPixel(16'hC0DE);

        // Reset in the middle of a byte; the next byte starts at bit 7
        partialBits(8'hE0, 3, 1'b0);
        doReset(1);
        applyStimulus(8'h5A, 1'b1, 1'b0);

        // An incomplete column window leaves the window unchanged
        applyStimulus(8'h2A, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h05, 1'b1, 1'b0);
        applyStimulus(8'h2C, 1'b0, 1'b0);
        sendPixel(16'hBEEF);

        // Random command stream
        for (int it = 0; it < 50; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                if ($urandom_range(0, 3) == 0) begin
                    s = $urandom_range(0, 65535);
                    e = $urandom_range(0, 65535);
                end else begin
                    s = $urandom_range(0, MASK);
                    e = (s + $urandom_range(0, 3) - 1) & MASK;
                end
                sendWindow((op <= 1) ? 8'h2A : 8'h2B, 16'(s), 16'(e));
            end else if (op <= 5) begin
                applyStimulus(8'h2C, 1'b0, 1'b0);
                n = $urandom_range(0, 7);
                for (int p = 0; p < n; p++) sendPixel(16'($urandom));
                if ($urandom_range(0, 2) == 0) applyStimulus(8'($urandom), 1'b1, 1'b0);
            end else if (op == 6) begin
                applyStimulus(($urandom_range(0, 1) == 0) ? 8'h2A : 8'h2B, 1'b0, 1'b0);
                n = $urandom_range(1, 3);
                for (int p = 0; p < n; p++) applyStimulus(8'($urandom), 1'b1, 1'b0);
            end else if (op == 7) begin
                applyStimulus(8'($urandom), 1'b0, 1'b0);
            end else if (op == 8) begin
                n = $urandom_range(1, 3);
                for (int p = 0; p < n; p++) applyStimulus(8'($urandom), 1'b1, 1'b0);
            end else begin
                partialBits(8'($urandom), $urandom_range(1, 7), 1'b1);
            end
        end

        // Bounded wait for the scoreboard to drain
        pending = exp_byte_q.size() + exp_cmd_q.size() + exp_pix_q.size();
        for (int i = 0; i < 200 && pending > 0; i++) begin
            @(negedge sys_clk_50MHz);
            pending = exp_byte_q.size() + exp_cmd_q.size() + exp_pix_q.size();
        end
        checkOutput("pending_bytes", 32'(exp_byte_q.size()), 32'd0);
        checkOutput("pending_cmds", 32'(exp_cmd_q.size()), 32'd0);
        checkOutput("pending_pixels", 32'(exp_pix_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
